// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared opcodes, condition/state enums and flag indices for ctrl_seq
package ctrl_seq_pkg;

  localparam logic [3:0] kBR   = 4'b1010;
  localparam logic [3:0] kLD   = 4'b0110;
  localparam logic [3:0] kHALT = 4'b1111;

  localparam int Z = 0;
  localparam int N = 1;
  localparam int C = 2;

  typedef enum logic [1:0] {
    ALWAYS  = 2'b00,
    ZERO    = 2'b01,
    NONZERO = 2'b10,
    NEG     = 2'b11
  } cond_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } ctrl_state_t;

  function automatic logic cond_true(input cond_t cond, input logic [2:0] flags);
    logic taken;
    case (cond)
      ALWAYS:  taken = 1'b1;
      ZERO:    taken = flags[Z];
      NONZERO: taken = !flags[Z];
      NEG:     taken = flags[N];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_seq_ld_stall_ctr.sv
// rtl/ctrl_seq_ld_stall_ctr.sv - loadable down-counter with zero detect for load wait cycles
module ld_stall_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - opcode sequencer: conditional branch on registered flags, load stall, halt
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW     = 9,
  parameter int OPW    = 4,
  parameter int LD_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [IW-1:0] Instruction,
  input  logic          ZeroIn,
  input  logic          NegIn,
  input  logic          CarryIn,
  input  logic          FlagWe,
  output logic          BranchEn,
  output logic          Stall,
  output logic          Done,
  output logic [2:0]    Flags
);

  localparam int CW = (LD_LAT < 1) ? 1 : $clog2(LD_LAT + 1);

  ctrl_state_t    state, state_next;
  logic [OPW-1:0] opcode;
  cond_t          cond;
  logic           stall_raw;
  logic           ctr_load, ctr_dec, ctr_zero;
  logic           unused_bits;

  assign opcode      = Instruction[IW-1 -: OPW];
  assign cond        = cond_t'(Instruction[IW-OPW-1 -: 2]);
  assign unused_bits = ^Instruction[IW-OPW-3:0];

  ld_stall_ctr #(.W(CW)) u_ld_stall_ctr (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (ctr_load),
    .dec   (ctr_dec),
    .value (CW'(LD_LAT - 1)),
    .zero  (ctr_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    case (state)
      RUN: begin
        if (opcode == kLD) begin
          stall_raw  = 1'b1;
          ctr_load   = 1'b1;
          state_next = WAIT;
        end else if (opcode == kHALT) begin
          stall_raw  = 1'b1;
          state_next = HALT;
        end
      end
      WAIT: begin
        // Final wait cycle releases the PC so it advances past the load
        if (!ctr_zero) begin
          stall_raw = 1'b1;
          ctr_dec   = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      HALT: begin
        stall_raw = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Flags <= 3'b000;
    end else if (FlagWe && (state == RUN) && !stall_raw) begin
      Flags[C] <= CarryIn;
      Flags[N] <= NegIn;
      Flags[Z] <= ZeroIn;
    end
  end

  assign Stall    = Reset && stall_raw;
  assign BranchEn = Reset && (state == RUN) && (opcode == kBR) && cond_true(cond, Flags);
  assign Done     = (state == HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed and random checks of three ctrl_seq instances (LD_LAT 2, 1, 4)
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam int IW = 9;
  localparam logic [3:0] kADD = 4'b0001;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [IW-1:0] Instruction;
  logic          ZeroIn, NegIn, CarryIn, FlagWe;
  logic [2:0]    br, st, dn;
  logic [8:0]    fl;

  int passed = 0;
  int total  = 0;

  int       lat    [3] = '{2, 1, 4};
  int       m_pos  [3];
  bit       m_halt [3];
  bit [2:0] m_flags[3];

  always #5 Clk = ~Clk;

  ctrl_seq #(.IW(IW), .OPW(4), .LD_LAT(2)) u0 (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .ZeroIn(ZeroIn), .NegIn(NegIn),
    .CarryIn(CarryIn), .FlagWe(FlagWe), .BranchEn(br[0]), .Stall(st[0]), .Done(dn[0]), .Flags(fl[2:0]));
  ctrl_seq #(.IW(IW), .OPW(4), .LD_LAT(1)) u1 (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .ZeroIn(ZeroIn), .NegIn(NegIn),
    .CarryIn(CarryIn), .FlagWe(FlagWe), .BranchEn(br[1]), .Stall(st[1]), .Done(dn[1]), .Flags(fl[5:3]));
  ctrl_seq #(.IW(IW), .OPW(4), .LD_LAT(4)) u2 (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .ZeroIn(ZeroIn), .NegIn(NegIn),
    .CarryIn(CarryIn), .FlagWe(FlagWe), .BranchEn(br[2]), .Stall(st[2]), .Done(dn[2]), .Flags(fl[8:6]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit taken(input logic [1:0] cnd, input bit [2:0] f);
    case (cnd)
      2'd0:    return 1'b1;
      2'd1:    return f[0];
      2'd2:    return !f[0];
      default: return f[1];
    endcase
  endfunction

  // One clock: drive at posedge+1, check mid-cycle, advance the model on the edge
  task automatic cycle(input logic rst, input logic [3:0] op, input logic [1:0] cnd,
                       input logic z, input logic n, input logic c, input logic we);
    bit e_st, e_br;
    Reset       = rst;
    Instruction = {op, cnd, 3'($urandom)};
    ZeroIn = z; NegIn = n; CarryIn = c; FlagWe = we;
    #4;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_halt[i] = 0; m_pos[i] = 0; m_flags[i] = 3'b000;
      end
      e_st = 0; e_br = 0;
      if (rst) begin
        if (m_halt[i])         e_st = 1;
        else if (m_pos[i] > 0) e_st = (m_pos[i] < lat[i]);
        else if (op == kLD || op == kHALT) e_st = 1;
        else if (op == kBR)    e_br = taken(cnd, m_flags[i]);
      end
      chk($sformatf("stall[%0d]", i), {3'b0, st[i]}, {3'b0, e_st});
      chk($sformatf("branch[%0d]", i), {3'b0, br[i]}, {3'b0, e_br});
      chk($sformatf("done[%0d]", i), {3'b0, dn[i]}, {3'b0, m_halt[i]});
      chk($sformatf("flags[%0d]", i), {1'b0, fl[3*i +: 3]}, {1'b0, m_flags[i]});
    end
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_halt[i] = 0; m_pos[i] = 0; m_flags[i] = 3'b000;
      end else if (m_halt[i]) begin
      end else if (m_pos[i] > 0) begin
        m_pos[i] = (m_pos[i] < lat[i]) ? m_pos[i] + 1 : 0;
      end else if (op == kLD) begin
        m_pos[i] = 1;
      end else if (op == kHALT) begin
        m_halt[i] = 1;
      end else if (we) begin
        m_flags[i] = {c, n, z};
      end
    end
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic       rr;
    Reset = 0; Instruction = '0; ZeroIn = 0; NegIn = 0; CarryIn = 0; FlagWe = 0;
    @(posedge Clk); #1;
    cycle(0, kBR, 2'd0, 0, 0, 0, 0);
    cycle(0, kLD, 2'd0, 1, 1, 1, 1);
    // Flags then branch: ZERO taken, NONZERO not
    cycle(1, kADD, 2'd0, 1, 0, 0, 1);
    cycle(1, kBR,  2'd1, 0, 0, 0, 0);
    cycle(1, kADD, 2'd0, 1, 0, 0, 1);
    cycle(1, kBR,  2'd2, 0, 0, 0, 0);
    // Same-cycle flag write on the branch sees old flags
    cycle(1, kADD, 2'd0, 0, 0, 0, 1);
    cycle(1, kBR,  2'd1, 1, 0, 0, 1);
    cycle(1, kBR,  2'd1, 0, 0, 0, 0);
    cycle(1, kADD, 2'd0, 0, 1, 1, 1);
    cycle(1, kBR,  2'd3, 0, 0, 0, 0);
    // Load stall with FlagWe asserted during stalled cycles
    cycle(1, kLD, 2'd0, 1, 1, 1, 1);
    for (int k = 0; k < 5; k++) cycle(1, kADD, 2'd0, 1, 0, 0, 1);
    cycle(1, kBR, 2'd1, 0, 0, 0, 0);
    // Reset in the second stalled cycle of a long load
    cycle(1, kLD, 2'd0, 0, 0, 0, 0);
    cycle(0, kLD, 2'd0, 0, 0, 0, 0);
    cycle(1, kBR, 2'd0, 0, 0, 0, 0);
    // Halt, branch ignored, then reset out of halt
    cycle(1, kHALT, 2'd0, 0, 0, 0, 0);
    cycle(1, kBR,   2'd0, 1, 1, 1, 1);
    cycle(1, kBR,   2'd0, 0, 0, 0, 0);
    cycle(0, kBR,   2'd0, 0, 0, 0, 0);
    cycle(1, kADD,  2'd0, 1, 0, 0, 1);
    cycle(1, kBR,   2'd1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      op = 4'($urandom);
      if (op == kHALT && $urandom_range(0, 3) != 0) op = kADD;
      if ($urandom_range(0, 3) == 0) op = kBR;
      rr = ($urandom_range(0, 29) != 0);
      cycle(rr, op, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
